// File: rtl/scale_pkg.sv
// Shared constants and FSM encoding for the scale grams-to-kilograms path.
package scale_pkg;

  localparam int unsigned DefaultWidth    = 14;
  localparam int unsigned DefaultDivisor  = 1000;
  localparam int unsigned DefaultMaxGrams = 9999;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StDivide = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/grams_divider.sv
// Repeated-subtraction divide by a constant DIVISOR; start loads the dividend,
// done is high in the cycle where the remainder has dropped below DIVISOR.
module grams_divider #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned DIVISOR = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] DivW = WIDTH'(DIVISOR);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             run_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= dividend;
      quo_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (rem_q >= DivW) begin
        rem_q <= rem_q - DivW;
        quo_q <= quo_q + WIDTH'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done      = run_q && (rem_q < DivW);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/scale_weight_controller.sv
// Grams-to-kilograms controller: tare offset, clamp to MAX_GRAMS, divide by DIVISOR.
// Define SCALE_AVERAGE_EN to average four accepted samples into each conversion.
module scale_weight_controller
  import scale_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned DIVISOR   = DefaultDivisor,
  parameter int unsigned MAX_GRAMS = DefaultMaxGrams
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sampleValid,
  output logic             sampleReady,
  input  logic [WIDTH-1:0] weightInGrams,
  input  logic             tareRequest,
  output logic [WIDTH-1:0] weightInKilogramsInteger,
  output logic [WIDTH-1:0] weightInKilogramsFraction,
  output logic             resultValid,
  output logic             overload,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MaxW = WIDTH'(MAX_GRAMS);

  state_e           state_q;
  logic [WIDTH-1:0] sample_q, tare_q, kg_int_q, kg_frac_q;
  logic             tare_pending_q, ovf_q, valid_q, overload_q;
  logic [WIDTH-1:0] diff, net, quotient, remainder;
  logic             borrow, ovf, accept, div_done;

`ifdef SCALE_AVERAGE_EN
  logic [WIDTH+1:0] acc_q;
  logic [1:0]       cnt_q;
  logic [WIDTH+1:0] acc_sum;
  assign acc_sum = acc_q + {2'b00, weightInGrams};
`endif

  assign accept = sampleValid & sampleReady;

  // Borrow out of the widened subtraction flags sample < tare.
  always_comb begin
    {borrow, diff} = {1'b0, sample_q} - {1'b0, tare_q};
    net = borrow ? '0 : diff;
    if (tare_pending_q) net = '0;
    ovf = 1'b0;
    if (net > MaxW) begin
      net = MaxW;
      ovf = 1'b1;
    end
  end

  grams_divider #(
    .WIDTH   (WIDTH),
    .DIVISOR (DIVISOR)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (state_q == StLoad),
    .dividend  (net),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      sample_q       <= '0;
      tare_q         <= '0;
      kg_int_q       <= '0;
      kg_frac_q      <= '0;
      tare_pending_q <= 1'b0;
      ovf_q          <= 1'b0;
      valid_q        <= 1'b0;
      overload_q     <= 1'b0;
`ifdef SCALE_AVERAGE_EN
      acc_q          <= '0;
      cnt_q          <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (tareRequest) tare_pending_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
`ifdef SCALE_AVERAGE_EN
          if (accept) begin
            if (cnt_q == 2'd3) begin
              sample_q <= acc_sum[WIDTH+1:2];
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StLoad;
            end else begin
              acc_q <= acc_sum;
              cnt_q <= cnt_q + 2'd1;
            end
          end
`else
          if (accept) begin
            sample_q <= weightInGrams;
            state_q  <= StLoad;
          end
`endif
        end
        StLoad: begin
          ovf_q <= ovf;
          // A request arriving in this very cycle stays pending for the next sample.
          if (tare_pending_q) begin
            tare_q <= sample_q;
            if (!tareRequest) tare_pending_q <= 1'b0;
          end
          state_q <= StDivide;
        end
        StDivide: begin
          if (div_done) begin
            kg_int_q   <= quotient;
            kg_frac_q  <= remainder;
            overload_q <= ovf_q;
            valid_q    <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sampleReady               = (state_q == StIdle) & ~reset;
  assign busy                      = (state_q != StIdle);
  assign resultValid               = valid_q;
  assign overload                  = overload_q;
  assign weightInKilogramsInteger  = kg_int_q;
  assign weightInKilogramsFraction = kg_frac_q;

endmodule

// File: doc/scale_weight_controller.md
Name: scale_weight_controller

Overview:
- Sequencing controller for the scale's grams-to-kilograms conversion path.
- Accepts raw gram samples through a valid/ready handshake, applies a tare offset, clamps to the display range, and divides by 1000 with a multi-cycle repeated-subtraction engine.
- Presents registered integer-kg and fractional-gram results with a one-cycle valid pulse.
- Sits between the load-cell sample source and the display/BCD stage.

Parameters:
- WIDTH, 14, bit width of every gram/kg bus.
- DIVISOR, 1000, grams per kilogram.
- MAX_GRAMS, 9999, upper clamp of the net weight; sets the overload threshold.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sampleValid  input  1  a raw sample is present on weightInGrams.
- sampleReady  output  1  controller can accept a sample this cycle.
- weightInGrams  input  WIDTH  raw unsigned gram sample.
- tareRequest  input  1  request to zero the scale; single-cycle pulse or level.
- weightInKilogramsInteger  output  WIDTH  integer kilograms, 0..9.
- weightInKilogramsFraction  output  WIDTH  remaining grams, 0..999.
- resultValid  output  1  one-cycle pulse when a new result is on the outputs.
- overload  output  1  the last result was clamped at MAX_GRAMS.
- busy  output  1  a conversion is in progress (state is not IDLE).

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: both weight outputs 0, resultValid 0, overload 0, busy 0, sampleReady 0, tare register 0, tarePending 0, state IDLE.
- sampleReady is 1 in every IDLE cycle after reset deasserts, and 0 in all other states.
- FSM states: IDLE, LOAD, DIVIDE, DONE.
  - IDLE -> LOAD on sampleValid & sampleReady. The sample is registered on that edge; this edge is called N.
  - LOAD (cycle N+1):
    - If tarePending: tare <= sample, net <= 0, clear tarePending.
    - Otherwise: net <= sample - tare, saturating at 0 when sample < tare.
    - Then if net > MAX_GRAMS: net <= MAX_GRAMS and set ovf.
    - Quotient register <= 0.
  - DIVIDE:
    - Each cycle, if rem >= DIVISOR: rem <= rem - DIVISOR and q <= q + 1.
    - Otherwise go to DONE.
    - DIVIDE therefore lasts q+1 cycles.
  - DONE (cycle N+3+q):
    - weightInKilogramsInteger <= q, weightInKilogramsFraction <= rem, overload <= ovf.
    - resultValid = 1 for this cycle only.
    - Next state is IDLE.
- Latency:
  - resultValid is high in cycle N+3+q.
  - Best case is N+3 for a 0 kg result; worst case is N+12 at 9999 g.
  - The next sample is accepted no earlier than cycle N+4+q.
- Outputs hold their last values until the next DONE; they are never cleared except by reset.
- Tare handling:
  - tareRequest in any cycle, including while busy, sets tarePending.
  - The next accepted sample becomes the tare and produces the result 0 kg, 0 g.
  - Multiple requests before that sample collapse into one.
- sampleValid outside IDLE is ignored; no sample is buffered or dropped silently beyond the handshake.
- Reset in any state aborts the conversion: no resultValid pulse is produced, tare is lost, and the first post-reset cycle is IDLE.
- All arithmetic is unsigned WIDTH bits; the subtraction uses the borrow to detect sample < tare.

Optional Feature:
- Macro: SCALE_AVERAGE_EN.
- Defined:
  - IDLE accepts 4 samples into a WIDTH+2-bit accumulator; a 2-bit counter tracks them.
  - The transition to LOAD happens on the 4th accepted sample, and LOAD uses sum >> 2 (truncating) in place of the raw sample.
  - Tare capture uses the averaged value.
  - Latency is counted from the 4th sample's acceptance edge.
  - Reset clears the accumulator and the counter.
- Undefined: every accepted sample yields exactly one result, and the accumulator and counter are absent.

Decomposition:
- scale_pkg holds:
  - WIDTH, DIVISOR, MAX_GRAMS default constants.
  - The state encoding constants IDLE/LOAD/DIVIDE/DONE.
- Sub-module grams_divider:
  - Repeated-subtraction unit with start/done handshake.
  - Inputs: dividend; outputs: quotient and remainder.
  - Owns the DIVIDE loop; the controller FSM waits on its done.

Test Plan:
- Reset, then sample 1500 (0b10111011100) at edge N -> resultValid high in cycle N+4, integer 1, fraction 500, overload 0.
- Sample 0 -> integer 0, fraction 0, resultValid in cycle N+3.
- Sample 12000 -> integer 9, fraction 999, overload 1, resultValid in cycle N+12.
- Pulse tareRequest, sample 200 -> result 0/0. Then sample 1700 -> result 1/500. Then sample 100 -> result 0/0 (saturated).
- tareRequest pulsed during DIVIDE of a 5000 g sample -> that result is 5/0 with the old tare. The next sample 3000 -> result 0/0, and tare is now 3000.
- Assert reset during DIVIDE of 9000 -> no resultValid pulse, outputs 0, sampleReady 1 in the first cycle after reset. Then sample 2250 -> result 2/250.
